x_uart_tx_sched: RTL and testbench
==================================

Name: x_uart_tx_sched

Overview:
Round-robin scheduler sharing one x_uart_tx byte transmitter between p_num_req packet sources. Grants one requester per packet (grant held until its last byte), registers each byte so the data is stable for the whole UART frame, and drives the transmitter's valid/data/accept handshake. Abandons a stalled packet after a timeout so other requesters are not starved.

Parameters:
p_num_req, 4, number of requesters (2..16)
p_timeout, 1024, max i_clk cycles waiting for the granted requester's next byte mid-packet (>=1)

Ports:
i_clk  input  1  clock
i_nrst  input  1  asynchronous active-low reset
i_req_data  input  8*p_num_req  byte from requester n on bits [8n+7:8n]
i_req_valid  input  p_num_req  requester n byte valid
i_req_last  input  p_num_req  requester n byte is last of packet (qualified by valid)
o_req_accept  output  p_num_req  one-hot byte-taken strobe, combinational from i_req_valid
o_uart_data  output  8  byte to transmitter i_data, registered
o_uart_valid  output  1  to transmitter i_valid, registered
i_uart_accept  input  1  transmitter o_accept (1-cycle pulse at end of stop bit)
o_grant_id  output  $clog2(p_num_req)  currently/last granted requester
o_busy  output  1  high while a packet is owned
o_err  output  1  1-cycle pulse on timeout abandon

Behaviour:
- Reset: i_nrst is asynchronous, active-low; clock is i_clk. All outputs 0; state IDLE; rr pointer = p_num_req-1, so requester 0 wins first; timeout counter 0.
- States: IDLE, SEND, FETCH (+HDR with optional feature).
- IDLE: o_busy=0, o_uart_valid=0. If any i_req_valid: pick first set bit searching from ptr+1 upward, wrapping. Same cycle: o_req_accept[g]=1, capture data and last flag into holding register, o_grant_id<=g. Next state SEND; o_uart_valid=1 on the following cycle (1-cycle latency).
- SEND: o_uart_valid=1, o_uart_data held constant. No o_req_accept. On i_uart_accept: o_uart_valid<=0. If held last=1, ptr<=g and go IDLE; else go FETCH with counter cleared.
- FETCH: o_uart_valid=0, counter increments each cycle. On i_req_valid[g]: o_req_accept[g]=1, capture, counter cleared, go SEND. Other requesters are ignored.
- Timeout: if counter reaches p_timeout-1 with no i_req_valid[g]: o_err pulse, ptr<=g, go IDLE. A valid on that same cycle wins over the timeout.
- o_uart_valid is never high in the cycle after i_uart_accept, so the transmitter returns to idle before the next byte.
- Exactly one o_req_accept bit high at most; never in SEND.
- Grant never changes mid-packet; i_req_last and i_req_data are sampled only with the accept.
- Single-requester streaming: the same requester is re-granted after IDLE if it is the only one valid.
- Reset mid-frame: all state cleared immediately; transmitter shares i_nrst; the partial packet is lost with no o_err.

Optional Feature:
X_UART_TX_SCHED_HDR_EN
- Defined: after the IDLE grant/capture, go to HDR instead of SEND. HDR: o_uart_valid=1, o_uart_data={4'hA, grant id zero-extended to 4 bits}. On i_uart_accept go SEND with the captured byte. One header per packet; FETCH->SEND paths unchanged.
- Undefined: no HDR state; IDLE goes directly to SEND.

Test Plan:
- Single byte: req0 valid, data 0x55, last=1 -> accept[0] pulses 1 cycle; next cycle uart_valid=1, data 0x55; model accept after 10 bit-times -> back to IDLE, o_busy=0.
- Round-robin: req0,req1,req3 all valid, single-byte packets -> grant order 0,1,3, then 0 again; o_grant_id matches each.
- Packet lock: req1 sends 3 bytes 0x01,0x02,0x03 (last on 0x03) while req0 valid throughout -> all 3 bytes from req1 sent contiguously, then req0 granted.
- Timeout: p_timeout=8, req2 sends byte without last then stalls -> o_err pulses 8 cycles after the accept; grant goes to the next valid requester; uart_valid stays low in FETCH.
- Timeout/valid collision: req2 valid on the final timeout cycle -> byte accepted, no o_err.
- HDR_EN: req3 packet 0x7E last -> uart sees 0xA3 then 0x7E; a mid-packet reset clears uart_valid and o_busy asynchronously.

Source files
------------

// File: rtl/x_uart_tx_sched.sv
// Round-robin scheduler sharing one UART byte transmitter between packet sources.
// Define X_UART_TX_SCHED_HDR_EN to prefix every packet with a {4'hA, grant id} header byte.
module x_uart_tx_sched #(
  parameter int p_num_req = 4,
  parameter int p_timeout = 1024
) (
  input  logic                         i_clk,
  input  logic                         i_nrst,
  input  logic [8*p_num_req-1:0]       i_req_data,
  input  logic [p_num_req-1:0]         i_req_valid,
  input  logic [p_num_req-1:0]         i_req_last,
  output logic [p_num_req-1:0]         o_req_accept,
  output logic [7:0]                   o_uart_data,
  output logic                         o_uart_valid,
  input  logic                         i_uart_accept,
  output logic [$clog2(p_num_req)-1:0] o_grant_id,
  output logic                         o_busy,
  output logic                         o_err
);

  localparam int p_id_w  = $clog2(p_num_req);
  localparam int p_cnt_w = $clog2(p_timeout + 1);
  localparam logic [p_cnt_w-1:0] p_cnt_last = p_cnt_w'(p_timeout - 1);

`ifdef X_UART_TX_SCHED_HDR_EN
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_SEND = 2'd1, ST_FETCH = 2'd2, ST_HDR = 2'd3} state_t;
`else
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_SEND = 2'd1, ST_FETCH = 2'd2} state_t;
`endif

  state_t              state_r;
  logic [p_id_w-1:0]   ptr_r;
  logic [p_cnt_w-1:0]  cnt_r;
  logic                hold_last_r;
`ifdef X_UART_TX_SCHED_HDR_EN
  logic [7:0]          hold_data_r;
`endif

  logic                pick_found_s;
  logic [p_id_w-1:0]   pick_id_s;
  logic [p_id_w-1:0]   sel_id_s;
  logic [7:0]          byte_s;
  logic                last_s;
  logic [p_num_req-1:0] acc_s;

  // First valid requester strictly after ptr, wrapping; MSB flags a hit.
  function automatic logic [p_id_w:0] rr_pick(input logic [p_num_req-1:0] valid,
                                               input logic [p_id_w-1:0] ptr);
    logic              found;
    logic [p_id_w-1:0] id;
    logic [p_id_w-1:0] cand;
    found = 1'b0;
    id    = {p_id_w{1'b0}};
    for (int i = 1; i <= p_num_req; i++) begin
      cand = p_id_w'((int'(ptr) + i) % p_num_req);
      if (!found && valid[cand]) begin
        found = 1'b1;
        id    = cand;
      end
    end
    return {found, id};
  endfunction

  function automatic logic [7:0] sel_byte(input logic [8*p_num_req-1:0] data,
                                          input logic [p_id_w-1:0] id);
    logic [7:0] b;
    b = 8'h00;
    for (int n = 0; n < p_num_req; n++) begin
      if (p_id_w'(n) == id) b = data[8*n +: 8];
    end
    return b;
  endfunction

  assign {pick_found_s, pick_id_s} = rr_pick(i_req_valid, ptr_r);
  assign sel_id_s = (state_r == ST_IDLE) ? pick_id_s : o_grant_id;
  assign byte_s   = sel_byte(i_req_data, sel_id_s);
  assign last_s   = i_req_last[sel_id_s];
  assign o_req_accept = acc_s;

  // Byte-taken strobe: new grant in IDLE, owner's next byte in FETCH, never otherwise.
  always_comb begin
    acc_s = {p_num_req{1'b0}};
    case (state_r)
      ST_IDLE: begin
        if (pick_found_s) acc_s[pick_id_s] = 1'b1;
        else acc_s = {p_num_req{1'b0}};
      end
      ST_FETCH: begin
        if (i_req_valid[o_grant_id]) acc_s[o_grant_id] = 1'b1;
        else acc_s = {p_num_req{1'b0}};
      end
      default: acc_s = {p_num_req{1'b0}};
    endcase
  end

  // Packet FSM with registered transmitter handshake and status outputs.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state_r      <= ST_IDLE;
      ptr_r        <= p_id_w'(p_num_req - 1);
      cnt_r        <= {p_cnt_w{1'b0}};
      hold_last_r  <= 1'b0;
`ifdef X_UART_TX_SCHED_HDR_EN
      hold_data_r  <= 8'h00;
`endif
      o_uart_data  <= 8'h00;
      o_uart_valid <= 1'b0;
      o_grant_id   <= {p_id_w{1'b0}};
      o_busy       <= 1'b0;
      o_err        <= 1'b0;
    end else begin
      o_err <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (pick_found_s) begin
            o_grant_id   <= pick_id_s;
            hold_last_r  <= last_s;
            o_busy       <= 1'b1;
            o_uart_valid <= 1'b1;
`ifdef X_UART_TX_SCHED_HDR_EN
            hold_data_r  <= byte_s;
            o_uart_data  <= {4'hA, 4'(pick_id_s)};
            state_r      <= ST_HDR;
`else
            o_uart_data  <= byte_s;
            state_r      <= ST_SEND;
`endif
          end else begin
            o_busy       <= 1'b0;
            o_uart_valid <= 1'b0;
          end
        end
`ifdef X_UART_TX_SCHED_HDR_EN
        ST_HDR: begin
          // Drop valid for one cycle so the transmitter idles between header and payload.
          if (o_uart_valid && i_uart_accept) begin
            o_uart_valid <= 1'b0;
            o_uart_data  <= hold_data_r;
            state_r      <= ST_SEND;
          end else begin
            o_uart_valid <= 1'b1;
          end
        end
`endif
        ST_SEND: begin
          if (!o_uart_valid) begin
            o_uart_valid <= 1'b1;
          end else if (i_uart_accept) begin
            o_uart_valid <= 1'b0;
            if (hold_last_r) begin
              ptr_r   <= o_grant_id;
              o_busy  <= 1'b0;
              state_r <= ST_IDLE;
            end else begin
              cnt_r   <= {p_cnt_w{1'b0}};
              state_r <= ST_FETCH;
            end
          end else begin
            o_uart_valid <= 1'b1;
          end
        end
        ST_FETCH: begin
          // A byte arriving on the final timeout cycle still wins.
          if (i_req_valid[o_grant_id]) begin
            o_uart_data  <= byte_s;
            hold_last_r  <= last_s;
            o_uart_valid <= 1'b1;
            cnt_r        <= {p_cnt_w{1'b0}};
            state_r      <= ST_SEND;
          end else if (cnt_r == p_cnt_last) begin
            o_err   <= 1'b1;
            ptr_r   <= o_grant_id;
            o_busy  <= 1'b0;
            cnt_r   <= {p_cnt_w{1'b0}};
            state_r <= ST_IDLE;
          end else begin
            cnt_r <= cnt_r + p_cnt_w'(1);
          end
        end
        default: begin
          o_uart_valid <= 1'b0;
          o_busy       <= 1'b0;
          state_r      <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_x_uart_tx_sched.sv
// Table-driven bench for x_uart_tx_sched (4 requesters, timeout 8).
module tb_x_uart_tx_sched;

  logic        i_clk;
  logic        i_nrst;
  logic [31:0] i_req_data;
  logic [3:0]  i_req_valid;
  logic [3:0]  i_req_last;
  logic [3:0]  o_req_accept;
  logic [7:0]  o_uart_data;
  logic        o_uart_valid;
  logic        i_uart_accept;
  logic [1:0]  o_grant_id;
  logic        o_busy;
  logic        o_err;

  int n_cmp = 0;
  int n_err = 0;

  x_uart_tx_sched #(.p_num_req(4), .p_timeout(8)) dut (
    .i_clk(i_clk), .i_nrst(i_nrst),
    .i_req_data(i_req_data), .i_req_valid(i_req_valid), .i_req_last(i_req_last),
    .o_req_accept(o_req_accept), .o_uart_data(o_uart_data), .o_uart_valid(o_uart_valid),
    .i_uart_accept(i_uart_accept), .o_grant_id(o_grant_id), .o_busy(o_busy), .o_err(o_err)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct {
    logic        rst;
    logic [3:0]  v;
    logic [3:0]  l;
    logic [31:0] d;
    logic        ua;
    logic [3:0]  e_acc;
    logic        e_uv;
    logic [7:0]  e_ud;
    logic [1:0]  e_gid;
    logic        e_busy;
    logic        e_err;
  } vec_t;

  vec_t vq[$];

  function automatic void add(input logic rst, input logic [3:0] v, input logic [3:0] l,
                              input logic [31:0] d, input logic ua, input logic [3:0] acc,
                              input logic uv, input logic [7:0] ud, input logic [1:0] gid,
                              input logic busy, input logic err);
    vec_t t;
    t.rst = rst; t.v = v; t.l = l; t.d = d; t.ua = ua;
    t.e_acc = acc; t.e_uv = uv; t.e_ud = ud; t.e_gid = gid; t.e_busy = busy; t.e_err = err;
    vq.push_back(t);
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s [%0d]: got %0h want %0h", nm, idx, act, exp);
    end
  endtask

  task automatic do_reset();
    i_nrst = 1'b0;
    i_req_valid = 4'b0000; i_req_last = 4'b0000; i_req_data = 32'h0; i_uart_accept = 1'b0;
    repeat (2) @(posedge i_clk);
    #1 i_nrst = 1'b1;
    #1;
    chk("rst_uv",   -1, {31'h0, o_uart_valid}, 32'h0);
    chk("rst_ud",   -1, {24'h0, o_uart_data},  32'h0);
    chk("rst_gid",  -1, {30'h0, o_grant_id},   32'h0);
    chk("rst_busy", -1, {31'h0, o_busy},       32'h0);
    chk("rst_err",  -1, {31'h0, o_err},        32'h0);
    chk("rst_acc",  -1, {28'h0, o_req_accept}, 32'h0);
  endtask

  initial begin
    logic bad;
    do_reset();

`ifdef X_UART_TX_SCHED_HDR_EN
    // Header 0xA3 precedes payload 0x7E, with a valid-low cycle between them.
    add(0, 4'b1000, 4'b1000, 32'h7E00_0000, 1'b0, 4'b1000, 1'b1, 8'hA3, 2'd3, 1'b1, 1'b0);
    add(0, 4'b0000, 4'b0000, 32'h0,         1'b0, 4'b0000, 1'b1, 8'hA3, 2'd3, 1'b1, 1'b0);
    add(0, 4'b0000, 4'b0000, 32'h0,         1'b1, 4'b0000, 1'b0, 8'h7E, 2'd3, 1'b1, 1'b0);
    add(0, 4'b0000, 4'b0000, 32'h0,         1'b0, 4'b0000, 1'b1, 8'h7E, 2'd3, 1'b1, 1'b0);
    add(0, 4'b0000, 4'b0000, 32'h0,         1'b1, 4'b0000, 1'b0, 8'h7E, 2'd3, 1'b0, 1'b0);
`else
    // Single byte, transmitter accepts after 10 cycles.
    add(0, 4'b0001, 4'b0001, 32'h0000_0055, 1'b0, 4'b0001, 1'b1, 8'h55, 2'd0, 1'b1, 1'b0);
    for (int k = 0; k < 9; k++)
      add(0, 4'b0000, 4'b0000, 32'h0, 1'b0, 4'b0000, 1'b1, 8'h55, 2'd0, 1'b1, 1'b0);
    add(0, 4'b0000, 4'b0000, 32'h0, 1'b1, 4'b0000, 1'b0, 8'h55, 2'd0, 1'b0, 1'b0);
    // Round-robin 0,1,3,0 from reset pointer.
    add(1, 4'b1011, 4'b1111, 32'h1300_1110, 1'b0, 4'b0001, 1'b1, 8'h10, 2'd0, 1'b1, 1'b0);
    add(0, 4'b1011, 4'b1111, 32'h1300_1110, 1'b1, 4'b0000, 1'b0, 8'h10, 2'd0, 1'b0, 1'b0);
    add(0, 4'b1011, 4'b1111, 32'h1300_1110, 1'b0, 4'b0010, 1'b1, 8'h11, 2'd1, 1'b1, 1'b0);
    add(0, 4'b1011, 4'b1111, 32'h1300_1110, 1'b1, 4'b0000, 1'b0, 8'h11, 2'd1, 1'b0, 1'b0);
    add(0, 4'b1011, 4'b1111, 32'h1300_1110, 1'b0, 4'b1000, 1'b1, 8'h13, 2'd3, 1'b1, 1'b0);
    add(0, 4'b1011, 4'b1111, 32'h1300_1110, 1'b1, 4'b0000, 1'b0, 8'h13, 2'd3, 1'b0, 1'b0);
    add(0, 4'b1011, 4'b1111, 32'h1300_1110, 1'b0, 4'b0001, 1'b1, 8'h10, 2'd0, 1'b1, 1'b0);
    add(0, 4'b1011, 4'b1111, 32'h1300_1110, 1'b1, 4'b0000, 1'b0, 8'h10, 2'd0, 1'b0, 1'b0);
    // Packet lock: req1 sends 01,02,03 while req0 waits.
    add(0, 4'b0011, 4'b0001, 32'h0000_0120, 1'b0, 4'b0010, 1'b1, 8'h01, 2'd1, 1'b1, 1'b0);
    add(0, 4'b0011, 4'b0001, 32'h0000_0120, 1'b0, 4'b0000, 1'b1, 8'h01, 2'd1, 1'b1, 1'b0);
    add(0, 4'b0011, 4'b0001, 32'h0000_0120, 1'b1, 4'b0000, 1'b0, 8'h01, 2'd1, 1'b1, 1'b0);
    add(0, 4'b0001, 4'b0001, 32'h0000_0120, 1'b0, 4'b0000, 1'b0, 8'h01, 2'd1, 1'b1, 1'b0);
    add(0, 4'b0011, 4'b0001, 32'h0000_0220, 1'b0, 4'b0010, 1'b1, 8'h02, 2'd1, 1'b1, 1'b0);
    add(0, 4'b0011, 4'b0001, 32'h0000_0220, 1'b1, 4'b0000, 1'b0, 8'h02, 2'd1, 1'b1, 1'b0);
    add(0, 4'b0011, 4'b0011, 32'h0000_0320, 1'b0, 4'b0010, 1'b1, 8'h03, 2'd1, 1'b1, 1'b0);
    add(0, 4'b0011, 4'b0011, 32'h0000_0320, 1'b1, 4'b0000, 1'b0, 8'h03, 2'd1, 1'b0, 1'b0);
    add(0, 4'b0001, 4'b0001, 32'h0000_0020, 1'b0, 4'b0001, 1'b1, 8'h20, 2'd0, 1'b1, 1'b0);
    add(0, 4'b0001, 4'b0001, 32'h0000_0020, 1'b1, 4'b0000, 1'b0, 8'h20, 2'd0, 1'b0, 1'b0);
    // Timeout: req2 stalls for 8 FETCH cycles, then req0 is granted.
    add(0, 4'b0100, 4'b0000, 32'h0042_0000, 1'b0, 4'b0100, 1'b1, 8'h42, 2'd2, 1'b1, 1'b0);
    add(0, 4'b0001, 4'b0001, 32'h0000_0030, 1'b1, 4'b0000, 1'b0, 8'h42, 2'd2, 1'b1, 1'b0);
    for (int k = 0; k < 7; k++)
      add(0, 4'b0001, 4'b0001, 32'h0000_0030, 1'b0, 4'b0000, 1'b0, 8'h42, 2'd2, 1'b1, 1'b0);
    add(0, 4'b0001, 4'b0001, 32'h0000_0030, 1'b0, 4'b0000, 1'b0, 8'h42, 2'd2, 1'b0, 1'b1);
    add(0, 4'b0001, 4'b0001, 32'h0000_0030, 1'b0, 4'b0001, 1'b1, 8'h30, 2'd0, 1'b1, 1'b0);
    add(0, 4'b0001, 4'b0001, 32'h0000_0030, 1'b1, 4'b0000, 1'b0, 8'h30, 2'd0, 1'b0, 1'b0);
    // Collision: req2 byte arrives on the last timeout cycle.
    add(0, 4'b0100, 4'b0000, 32'h0044_0000, 1'b0, 4'b0100, 1'b1, 8'h44, 2'd2, 1'b1, 1'b0);
    add(0, 4'b0000, 4'b0000, 32'h0,         1'b1, 4'b0000, 1'b0, 8'h44, 2'd2, 1'b1, 1'b0);
    for (int k = 0; k < 7; k++)
      add(0, 4'b0000, 4'b0000, 32'h0, 1'b0, 4'b0000, 1'b0, 8'h44, 2'd2, 1'b1, 1'b0);
    add(0, 4'b0100, 4'b0100, 32'h0045_0000, 1'b0, 4'b0100, 1'b1, 8'h45, 2'd2, 1'b1, 1'b0);
    add(0, 4'b0000, 4'b0000, 32'h0,         1'b1, 4'b0000, 1'b0, 8'h45, 2'd2, 1'b0, 1'b0);
`endif

    foreach (vq[k]) begin
      if (vq[k].rst) do_reset();
      i_req_valid = vq[k].v; i_req_last = vq[k].l; i_req_data = vq[k].d; i_uart_accept = vq[k].ua;
      #1;
      chk("accept", k, {28'h0, o_req_accept}, {28'h0, vq[k].e_acc});
      @(posedge i_clk);
      #1;
      chk("uart_valid", k, {31'h0, o_uart_valid}, {31'h0, vq[k].e_uv});
      chk("uart_data",  k, {24'h0, o_uart_data},  {24'h0, vq[k].e_ud});
      chk("grant_id",   k, {30'h0, o_grant_id},   {30'h0, vq[k].e_gid});
      chk("busy",       k, {31'h0, o_busy},       {31'h0, vq[k].e_busy});
      chk("err",        k, {31'h0, o_err},        {31'h0, vq[k].e_err});
    end

    // Mid-packet asynchronous reset: outputs clear without a clock edge, no error afterwards.
    i_req_valid = 4'b0010; i_req_last = 4'b0000; i_req_data = 32'h0000_6600; i_uart_accept = 1'b0;
    @(posedge i_clk);
    #1;
    chk("mid_uv_pre",   0, {31'h0, o_uart_valid}, 32'h1);
    chk("mid_busy_pre", 0, {31'h0, o_busy},       32'h1);
    i_req_valid = 4'b0000;
    #3 i_nrst = 1'b0;
    #1;
    chk("mid_uv",   0, {31'h0, o_uart_valid}, 32'h0);
    chk("mid_busy", 0, {31'h0, o_busy},       32'h0);
    chk("mid_gid",  0, {30'h0, o_grant_id},   32'h0);
    chk("mid_err",  0, {31'h0, o_err},        32'h0);
    @(posedge i_clk);
    #1 i_nrst = 1'b1;
    bad = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(posedge i_clk);
      #1;
      if (o_err || o_busy || o_uart_valid) bad = 1'b1;
    end
    chk("post_rst_quiet", 0, {31'h0, bad}, 32'h0);
    i_req_valid = 4'b1111; i_req_last = 4'b1111; i_req_data = 32'h0404_0404;
    #1;
    chk("post_rst_acc", 0, {28'h0, o_req_accept}, 32'h1);
    @(posedge i_clk);
    #1;
    chk("post_rst_gid", 0, {30'h0, o_grant_id}, 32'h0);
    chk("post_rst_uv",  0, {31'h0, o_uart_valid}, 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
